sbox_scheduler: RTL and testbench
=================================

Name: sbox_scheduler

Overview:
- Time-multiplexes a pool of 4 sBox byte-substitution lanes between two requesters.
- Requester 1, the round datapath, sends 128-bit SubBytes jobs.
- Requester 2, key expansion, sends 32-bit SubWord jobs.
- Arbitrates between them, sequences 128-bit jobs over 4 beats, and returns each result on a valid/ready response channel. This removes the 16+4 dedicated sBox instances from the round and key-schedule logic.

Parameters:
- LANES, 4, number of sBox instances; fixed at 4 (one 32-bit word per beat); any other value is a parse-time error.
- BEATS, 16/LANES = 4, beats per state job; derived, not overridable.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- st_req_valid  in  1  state job offered.
- st_req_ready  out  1  state job accepted this cycle.
- st_req_data  in  128  state to substitute.
- st_rsp_valid  out  1  state result available.
- st_rsp_ready  in  1  state result consumed.
- st_rsp_data  out  128  substituted state.
- key_req_valid  in  1  key word offered.
- key_req_ready  out  1  key word accepted this cycle.
- key_req_data  in  32  word to substitute (post-RotWord).
- key_rsp_valid  out  1  key result available.
- key_rsp_ready  in  1  key result consumed.
- key_rsp_data  out  32  substituted word.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - FSM = IDLE; all ready/valid outputs = 0; rsp data registers = 0; beat counter = 0.
  - last_grant = ST, so key wins the first tie.
- Lane mapping: lane i substitutes bits [8i+7:8i] of the current 32-bit beat word. Beat k of a state job covers st bits [32k+31:32k], k = 0..3, in ascending order.
- FSM states: IDLE, ST_RUN, KEY_RUN, ST_DONE, KEY_DONE.
- IDLE:
  - The ready outputs are a combinational function of FSM state, both req_valid inputs and last_grant only; never of rsp_ready.
  - Only one requester is granted.
  - If only one valid, its ready = 1.
  - If both valid, grant the requester not equal to last_grant (round-robin).
  - On handshake (cycle 0): capture req_data into the job buffer, update last_grant, go to ST_RUN (beat = 0) or KEY_RUN.
  - Ready = 0 in every state other than IDLE.
- ST_RUN:
  - Each cycle, lanes compute beat `beat`; result written into st_rsp_data slice `beat` at end of cycle; beat++.
  - After beat 3, go to ST_DONE.
  - Timing: beats occupy cycles 1-4; st_rsp_valid = 1 from cycle 5.
- KEY_RUN: lanes compute the word in cycle 1; result registered into key_rsp_data; go to KEY_DONE. key_rsp_valid = 1 from cycle 2.
- DONE states:
  - rsp_valid held high and rsp_data held stable until rsp_ready = 1.
  - On rsp handshake: valid drops next cycle and FSM returns to IDLE.
  - A new request is accepted no earlier than the cycle after the rsp handshake.
- Minimum throughput:
  - State job: one per 6 cycles.
  - Key job: one per 3 cycles.
- Lane inputs when not in a RUN state are don't-care; the spec requires no lane toggling suppression.
- Response data registers retain their last value after the handshake until overwritten by the next job of the same type.
- rst asserted mid-job:
  - Job aborted and discarded; all outputs return to reset values the next cycle.
  - No response is produced for the aborted job.
- req_valid deasserting while not granted is legal; the scheduler does not require valid to be sticky.
- No ordering guarantee between the two requesters beyond round-robin.

Decomposition:
- Shared package aes_pkg:
  - byte_t, word_t, state_t (128-bit) typedefs.
  - SBOX_LANES = 4 constant.
  - sched_state_e enum (IDLE, ST_RUN, KEY_RUN, ST_DONE, KEY_DONE).
  - requester enum (ST, KEY) for last_grant.
- Sub-modules:
  - Instantiate the existing sBox module 4 times via a generate loop; no new leaf needed.
  - Optional sub-module sbox_lane_word (4 sBox instances, 32-bit in/out), also reusable by key expansion.

Test Plan:
- State job st_req_data = 0 -> st_rsp_valid in cycle 5, st_rsp_data = 0x63636363_63636363_63636363_63636363.
- State job 0x000102030405060708090a0b0c0d0e0f (bits [7:0] = 0x0f) -> 0x637c777bf26b6fc53001672bfed7ab76. Checks that beat ordering keeps byte positions.
- Key job 0x00010203 -> key_rsp_valid in cycle 2, key_rsp_data = 0x637c777b; key 0xffffffff -> 0x16161616.
- Both requesters valid continuously from reset:
  - Grants alternate KEY, ST, KEY, ST.
  - Never two consecutive grants to the same side while both are valid.
- st_rsp_ready held low 3 cycles after st_rsp_valid:
  - Data is stable and valid held throughout.
  - st_req_ready/key_req_ready stay 0 until the handshake completes.
- rst pulsed in cycle 2 of a state job -> no st_rsp_valid for that job; the next job returns the correct result with nominal latency.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, sBox lane count, scheduler FSM encoding and the byte-substitution table.
// Latency: n/a (types and a pure combinational lookup function).
// Backpressure: n/a.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  // One 32-bit word is substituted per beat.
  localparam int SBOX_LANES = 4;

  typedef enum logic [2:0] {
    IDLE,
    ST_RUN,
    KEY_RUN,
    ST_DONE,
    KEY_DONE
  } sched_state_e;

  typedef enum logic {
    ST,
    KEY
  } requester_e;

  // Forward S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox_fn(input byte_t b);
    logic [7:0] idx;
    idx = 8'hff - b;
    return SBOX_TABLE[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sbox_scheduler_lane_word.sv
// Single-byte forward S-box lookup.
// Latency: combinational.
// Backpressure: none.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = sbox_fn(in_byte);

endmodule

// Four S-box lanes substituting one 32-bit word; lane i handles bits [8i+7:8i].
// Latency: combinational.
// Backpressure: none.
module sbox_lane_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar i = 0; i < SBOX_LANES; i++) begin : g_lane
    sbox u_sbox (
      .in_byte  (word_in[8*i +: 8]),
      .out_byte (word_out[8*i +: 8])
    );
  end

endmodule

// File: rtl/sbox_scheduler.sv
// Shares one 4-lane sBox word between state SubBytes jobs and key SubWord jobs, round-robin.
// Latency: state result valid 5 cycles after request handshake, key result 2 cycles after.
// Backpressure: one job in flight; requests stall until the pending response is consumed.
module sbox_scheduler
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_req_data,
  output logic         key_rsp_valid,
  input  logic         key_rsp_ready,
  output logic [31:0]  key_rsp_data
);

  localparam int BEATS = 16 / LANES;

  // The lane wiring below only exists for a 4-lane pool.
  if (LANES != SBOX_LANES) begin : g_bad_lanes
    $error("sbox_scheduler: LANES must be 4");
  end

  sched_state_e state_q;
  logic [1:0]   beat_q;
  requester_e   last_grant_q;
  state_t       job_q;
  word_t        lane_in;
  word_t        lane_out;

  // Grant in IDLE only; on contention the side not served last wins.
  always_comb begin
    st_req_ready  = 1'b0;
    key_req_ready = 1'b0;
    if (!rst && state_q == IDLE) begin
      st_req_ready  = st_req_valid  && (!key_req_valid || last_grant_q == KEY);
      key_req_ready = key_req_valid && (!st_req_valid  || last_grant_q == ST);
    end
  end

  // Key words sit in the low word of the job buffer; state beats walk upward.
  always_comb begin
    lane_in = job_q[{beat_q, 5'b00000} +: 32];
    if (state_q == KEY_RUN) begin
      lane_in = job_q[31:0];
    end
  end

  sbox_lane_word u_lanes (
    .word_in  (lane_in),
    .word_out (lane_out)
  );

  // Scheduler FSM with registered response channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= 2'd0;
      last_grant_q  <= ST;
      job_q         <= '0;
      st_rsp_valid  <= 1'b0;
      st_rsp_data   <= '0;
      key_rsp_valid <= 1'b0;
      key_rsp_data  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (st_req_ready) begin
            job_q        <= st_req_data;
            last_grant_q <= ST;
            beat_q       <= 2'd0;
            state_q      <= ST_RUN;
          end else if (key_req_ready) begin
            job_q        <= {96'd0, key_req_data};
            last_grant_q <= KEY;
            state_q      <= KEY_RUN;
          end
        end
        ST_RUN: begin
          st_rsp_data[{beat_q, 5'b00000} +: 32] <= lane_out;
          beat_q <= beat_q + 2'd1;
          if (beat_q == 2'(BEATS - 1)) begin
            st_rsp_valid <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        KEY_RUN: begin
          key_rsp_data  <= lane_out;
          key_rsp_valid <= 1'b1;
          state_q       <= KEY_DONE;
        end
        ST_DONE: begin
          if (st_rsp_ready) begin
            st_rsp_valid <= 1'b0;
            state_q      <= IDLE;
          end
        end
        KEY_DONE: begin
          if (key_rsp_ready) begin
            key_rsp_valid <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_scheduler.sv
// Self-checking bench: vector table plus scoreboard queues for both response channels.
// Latency: checks 5-cycle state and 2-cycle key response timing.
// Backpressure: exercises held responses, round-robin contention and mid-job reset.
module tb_sbox_scheduler;

  logic         clk;
  logic         rst;
  logic         st_req_valid;
  logic         st_req_ready;
  logic [127:0] st_req_data;
  logic         st_rsp_valid;
  logic         st_rsp_ready;
  logic [127:0] st_rsp_data;
  logic         key_req_valid;
  logic         key_req_ready;
  logic [31:0]  key_req_data;
  logic         key_rsp_valid;
  logic         key_rsp_ready;
  logic [31:0]  key_rsp_data;

  sbox_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .st_req_valid  (st_req_valid),
    .st_req_ready  (st_req_ready),
    .st_req_data   (st_req_data),
    .st_rsp_valid  (st_rsp_valid),
    .st_rsp_ready  (st_rsp_ready),
    .st_rsp_data   (st_rsp_data),
    .key_req_valid (key_req_valid),
    .key_req_ready (key_req_ready),
    .key_req_data  (key_req_data),
    .key_rsp_valid (key_rsp_valid),
    .key_rsp_ready (key_rsp_ready),
    .key_rsp_data  (key_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         is_key;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs [8];
  int           applied;
  int           miscompares;
  logic [127:0] st_q [$];
  logic [127:0] key_q [$];
  logic         grant_log [$];
  logic [127:0] st_exp_next;
  logic [31:0]  key_exp_next;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    applied = applied + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: push expectations at request handshakes, compare at response handshakes.
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst) begin
      if (st_req_ready && key_req_ready) chk("single_grant", 128'd1, 128'd0);
      if (st_req_valid && st_req_ready) begin
        st_q.push_back(st_exp_next);
        grant_log.push_back(1'b0);
      end
      if (key_req_valid && key_req_ready) begin
        key_q.push_back({96'd0, key_exp_next});
        grant_log.push_back(1'b1);
      end
      if (st_rsp_valid && st_rsp_ready) begin
        if (st_q.size() == 0) chk("st_unexpected_rsp", st_rsp_data, 128'hx);
        else begin
          e = st_q.pop_front();
          chk("st_rsp_data", st_rsp_data, e);
        end
      end
      if (key_rsp_valid && key_rsp_ready) begin
        if (key_q.size() == 0) chk("key_unexpected_rsp", {96'd0, key_rsp_data}, 128'hx);
        else begin
          e = key_q.pop_front();
          chk("key_rsp_data", {96'd0, key_rsp_data}, e);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Offer one job, wait for its grant, then measure cycles from handshake to response valid.
  task automatic run_vec(input int idx);
    int   n;
    int   lat;
    vec_t v;
    v = vecs[idx];
    if (v.is_key) begin
      key_req_data  = v.din[31:0];
      key_exp_next  = v.exp[31:0];
      key_req_valid = 1'b1;
    end else begin
      st_req_data  = v.din;
      st_exp_next  = v.exp;
      st_req_valid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!(v.is_key ? key_req_ready : st_req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    st_req_valid  = 1'b0;
    key_req_valid = 1'b0;
    lat = 1;
    while (!(v.is_key ? key_rsp_valid : st_rsp_valid) && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("latency[%0d]", idx), 128'(lat), v.is_key ? 128'd2 : 128'd5);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int seen;
    applied      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    st_req_valid = 1'b0;
    st_req_data  = '0;
    st_rsp_ready = 1'b1;
    key_req_valid = 1'b0;
    key_req_data = '0;
    key_rsp_ready = 1'b1;
    st_exp_next  = '0;
    key_exp_next = '0;

    vecs[0] = '{1'b0, 128'h0, 128'h63636363_63636363_63636363_63636363};
    vecs[1] = '{1'b0, 128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h637c777b_f26b6fc5_3001672b_fed7ab76};
    vecs[2] = '{1'b1, 128'h00010203, 128'h637c777b};
    vecs[3] = '{1'b1, 128'hffffffff, 128'h16161616};
    vecs[4] = '{1'b0, 128'hffeeddcc_bbaa9988_77665544_33221100, 128'h1628c14b_eaaceec4_f533fc1b_c3938263};
    vecs[5] = '{1'b1, 128'h53535353, 128'hedededed};
    vecs[6] = '{1'b1, 128'hf0f1f2f3, 128'h8ca1890d};
    vecs[7] = '{1'b0, 128'h10111213_53535353_f0f1f2f3_ffffffff, 128'hca82c97d_edededed_8ca1890d_16161616};

    do_reset();
    @(negedge clk);
    chk("reset_st_req_ready", 128'(st_req_ready), 128'd0);
    chk("reset_key_req_ready", 128'(key_req_ready), 128'd0);
    chk("reset_st_rsp_valid", 128'(st_rsp_valid), 128'd0);
    chk("reset_key_rsp_valid", 128'(key_rsp_valid), 128'd0);
    chk("reset_st_rsp_data", st_rsp_data, 128'd0);
    chk("reset_key_rsp_data", 128'(key_rsp_data), 128'd0);

    // Both sides valid continuously: grants must alternate starting with key.
    @(posedge clk);
    #1;
    st_req_data   = vecs[1].din;
    st_exp_next   = vecs[1].exp;
    key_req_data  = vecs[2].din[31:0];
    key_exp_next  = vecs[2].exp[31:0];
    st_req_valid  = 1'b1;
    key_req_valid = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    st_req_valid  = 1'b0;
    key_req_valid = 1'b0;
    chk("rr_grant_count", 128'(grant_log.size()), 128'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      chk($sformatf("rr_grant[%0d]", i), 128'(grant_log[i]), (i % 2 == 0) ? 128'd1 : 128'd0);
    end
    n = 0;
    while ((st_q.size() != 0 || key_q.size() != 0 || st_rsp_valid || key_rsp_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rr_drained", 128'(st_q.size() + key_q.size()), 128'd0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Held state response: valid and data stable, no new grants while it waits.
    st_rsp_ready  = 1'b0;
    st_req_data   = vecs[4].din;
    st_exp_next   = vecs[4].exp;
    st_req_valid  = 1'b1;
    @(negedge clk);
    chk("bp_st_granted", 128'(st_req_ready), 128'd1);
    @(posedge clk);
    #1;
    key_req_data  = vecs[5].din[31:0];
    key_exp_next  = vecs[5].exp[31:0];
    key_req_valid = 1'b1;
    n = 0;
    while (!st_rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid[%0d]", i), 128'(st_rsp_valid), 128'd1);
      chk($sformatf("bp_data[%0d]", i), st_rsp_data, vecs[4].exp);
      chk($sformatf("bp_rdy[%0d]", i), 128'({st_req_ready, key_req_ready}), 128'd0);
      @(posedge clk);
      #1;
    end
    st_req_valid  = 1'b0;
    key_req_valid = 1'b0;
    st_rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_drop", 128'(st_rsp_valid), 128'd0);
    chk("bp_data_retained", st_rsp_data, vecs[4].exp);

    // Reset in cycle 2 of a state job: no response, then a clean job with nominal latency.
    st_req_data  = vecs[7].din;
    st_exp_next  = vecs[7].exp;
    st_req_valid = 1'b1;
    @(negedge clk);
    chk("abort_granted", 128'(st_req_ready), 128'd1);
    @(posedge clk);
    #1;
    st_req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    st_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_data_cleared", st_rsp_data, 128'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (st_rsp_valid) seen++;
    end
    chk("abort_no_rsp", 128'(seen), 128'd0);
    run_vec(1);

    chk("final_st_pending", 128'(st_q.size()), 128'd0);
    chk("final_key_pending", 128'(key_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
